// File: rtl/rps_match_scorer.sv
// rps_match_scorer: match-level scorekeeper for rock-paper-scissors.
// Takes the 2-bit round code from the round judge, keeps user/FPGA/draw
// tallies, holds each accepted round on display for DISP_HOLD cycles and
// runs a first-to-WIN_TARGET match (IDLE -> PLAY <-> SHOW -> OVER).
// Optional build macro RPS_HISTORY_EN enables the 8-deep history of
// accepted round codes; without it history is tied to zero.
module rps_match_scorer #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int DISP_HOLD  = 25000000
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [1:0]         result_in,
  input  logic               result_valid,
  input  logic               new_match,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] fpga_score,
  output logic [SCORE_W-1:0] draw_count,
  output logic [7:0]         round_count,
  output logic               round_ack,
  output logic [1:0]         last_result,
  output logic [1:0]         state,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic [15:0]        history
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    SHOW = 2'b10,
    OVER = 2'b11
  } state_t;

  // Hold counter only needs to reach DISP_HOLD-1; keep at least one bit.
  localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(DISP_HOLD - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_TARGET);

  state_t             state_reg,  state_next;
  logic [HOLD_W-1:0]  hold_reg,   hold_next;
  logic [SCORE_W-1:0] user_reg,   user_next;
  logic [SCORE_W-1:0] fpga_reg,   fpga_next;
  logic [SCORE_W-1:0] draw_reg,   draw_next;
  logic [7:0]         round_reg,  round_next;
  logic               ack_reg,    ack_next;
  logic [1:0]         last_reg,   last_next;
  logic               done_reg,   done_next;
  logic [1:0]         winner_reg, winner_next;

  // Next-state and next-tally logic; new_match overrides everything else.
  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    user_next   = user_reg;
    fpga_next   = fpga_reg;
    draw_next   = draw_reg;
    round_next  = round_reg;
    ack_next    = 1'b0;
    last_next   = last_reg;
    done_next   = done_reg;
    winner_next = winner_reg;

    if (new_match) begin
      state_next  = PLAY;
      hold_next   = '0;
      user_next   = '0;
      fpga_next   = '0;
      draw_next   = '0;
      round_next  = '0;
      last_next   = 2'b00;
      done_next   = 1'b0;
      winner_next = 2'b00;
    end else begin
      case (state_reg)
        PLAY: begin
          if (result_valid && (result_in != 2'b00)) begin
            case (result_in)
              2'b10:   user_next = user_reg + 1'b1;
              2'b01:   fpga_next = fpga_reg + 1'b1;
              default: begin
                // Draw tally sticks at all-ones rather than wrapping.
                if (draw_reg != {SCORE_W{1'b1}}) draw_next = draw_reg + 1'b1;
              end
            endcase
            round_next = round_reg + 8'd1;
            last_next  = result_in;
            ack_next   = 1'b1;
            hold_next  = '0;
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (hold_reg == HOLD_LAST) begin
            hold_next = '0;
            if (user_reg == WIN_VAL) begin
              state_next  = OVER;
              winner_next = 2'b10;
              done_next   = 1'b1;
            end else if (fpga_reg == WIN_VAL) begin
              state_next  = OVER;
              winner_next = 2'b01;
              done_next   = 1'b1;
            end else begin
              state_next = PLAY;
            end
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end
        default: ;  // IDLE and OVER wait for new_match
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      user_reg   <= '0;
      fpga_reg   <= '0;
      draw_reg   <= '0;
      round_reg  <= '0;
      ack_reg    <= 1'b0;
      last_reg   <= 2'b00;
      done_reg   <= 1'b0;
      winner_reg <= 2'b00;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      user_reg   <= user_next;
      fpga_reg   <= fpga_next;
      draw_reg   <= draw_next;
      round_reg  <= round_next;
      ack_reg    <= ack_next;
      last_reg   <= last_next;
      done_reg   <= done_next;
      winner_reg <= winner_next;
    end
  end

`ifdef RPS_HISTORY_EN
  logic [15:0] history_reg;

  // Shift each accepted code in at the bottom; new_match wipes the record.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      history_reg <= 16'h0000;
    end else if (new_match) begin
      history_reg <= 16'h0000;
    end else if ((state_reg == PLAY) && result_valid && (result_in != 2'b00)) begin
      history_reg <= {history_reg[13:0], result_in};
    end
  end

  assign history = history_reg;
`else
  assign history = 16'h0000;
`endif

  assign user_score   = user_reg;
  assign fpga_score   = fpga_reg;
  assign draw_count   = draw_reg;
  assign round_count  = round_reg;
  assign round_ack    = ack_reg;
  assign last_result  = last_reg;
  assign state        = state_reg;
  assign match_done   = done_reg;
  assign match_winner = winner_reg;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer (WIN_TARGET=3, SCORE_W=3,
// DISP_HOLD=4). Expected per-round snapshots are queued when an accepted
// round is driven and compared when round_ack appears.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [1:0] result_in = 2'b00;
  logic       result_valid = 1'b0;
  logic       new_match = 1'b0;
  logic [2:0] user_score, fpga_score, draw_count;
  logic [7:0] round_count;
  logic       round_ack;
  logic [1:0] last_result, state, match_winner;
  logic       match_done;
  logic [15:0] history;

  rps_match_scorer #(
    .WIN_TARGET(3),
    .SCORE_W(3),
    .DISP_HOLD(4)
  ) dut (
    .clk(clk),
    .clear(clear),
    .result_in(result_in),
    .result_valid(result_valid),
    .new_match(new_match),
    .user_score(user_score),
    .fpga_score(fpga_score),
    .draw_count(draw_count),
    .round_count(round_count),
    .round_ack(round_ack),
    .last_result(last_result),
    .state(state),
    .match_done(match_done),
    .match_winner(match_winner),
    .history(history)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  u;
    logic [2:0]  f;
    logic [2:0]  d;
    logic [7:0]  r;
    logic [1:0]  l;
    logic [15:0] h;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the tallies
  logic [2:0]  m_user = '0, m_fpga = '0, m_draw = '0;
  logic [7:0]  m_rounds = '0;
  logic [1:0]  m_last = '0;
  logic [15:0] m_hist = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle strobe of the inputs; returns 1ns after the sampling edge
  task automatic pulse(input logic rv, input logic [1:0] code, input logic nm);
    result_valid = rv;
    result_in    = code;
    new_match    = nm;
    step(1);
    result_valid = 1'b0;
    result_in    = 2'b00;
    new_match    = 1'b0;
  endtask

  task automatic model_new_match();
    m_user = '0; m_fpga = '0; m_draw = '0;
    m_rounds = '0; m_last = '0; m_hist = '0;
  endtask

  // drive a round the DUT should accept; leaves time at the ack cycle
  task automatic accept_round(input logic [1:0] code);
    exp_t e;
    case (code)
      2'b10:   m_user = m_user + 3'd1;
      2'b01:   m_fpga = m_fpga + 3'd1;
      default: if (m_draw != 3'd7) m_draw = m_draw + 3'd1;
    endcase
    m_rounds = m_rounds + 8'd1;
    m_last   = code;
`ifdef RPS_HISTORY_EN
    m_hist   = {m_hist[13:0], code};
`endif
    e.u = m_user; e.f = m_fpga; e.d = m_draw; e.r = m_rounds; e.l = m_last; e.h = m_hist;
    exp_q.push_back(e);
    pulse(1'b1, code, 1'b0);
    check_eq("ack_on_accept", {31'd0, round_ack}, 32'd1);
    check_eq("state_show", {30'd0, state}, 32'd2);
  endtask

  // scoreboard: every round_ack must match the oldest queued snapshot
  always @(negedge clk) begin
    if (round_ack) begin
      if (exp_q.size() == 0) begin
        check_eq("ack_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] round %0d code %b user %0d fpga %0d draw %0d hist %h",
                 round_count, last_result, user_score, fpga_score, draw_count, history);
        check_eq("sb_user",  {29'd0, user_score},  {29'd0, e.u});
        check_eq("sb_fpga",  {29'd0, fpga_score},  {29'd0, e.f});
        check_eq("sb_draw",  {29'd0, draw_count},  {29'd0, e.d});
        check_eq("sb_round", {24'd0, round_count}, {24'd0, e.r});
        check_eq("sb_last",  {30'd0, last_result}, {30'd0, e.l});
        check_eq("sb_hist",  {16'd0, history},     {16'd0, e.h});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_user"},  {29'd0, user_score},   32'd0);
    check_eq({tag, "_fpga"},  {29'd0, fpga_score},   32'd0);
    check_eq({tag, "_draw"},  {29'd0, draw_count},   32'd0);
    check_eq({tag, "_round"}, {24'd0, round_count},  32'd0);
    check_eq({tag, "_ack"},   {31'd0, round_ack},    32'd0);
    check_eq({tag, "_last"},  {30'd0, last_result},  32'd0);
    check_eq({tag, "_state"}, {30'd0, state},        32'd0);
    check_eq({tag, "_done"},  {31'd0, match_done},   32'd0);
    check_eq({tag, "_win"},   {30'd0, match_winner}, 32'd0);
    check_eq({tag, "_hist"},  {16'd0, history},      32'd0);
  endtask

  initial begin
    // reset state
    step(3);
    check_all_zero("reset");
    clear = 1'b0;
    step(1);

    // IDLE ignores results
    pulse(1'b1, 2'b10, 1'b0);
    check_eq("idle_ignore_state", {30'd0, state}, 32'd0);
    check_eq("idle_ignore_user", {29'd0, user_score}, 32'd0);

    // start match
    pulse(1'b0, 2'b00, 1'b1);
    model_new_match();
    check_eq("nm_state_play", {30'd0, state}, 32'd1);

    // first user win and SHOW duration
    accept_round(2'b10);
    check_eq("first_user", {29'd0, user_score}, 32'd1);
    step(1);
    check_eq("ack_one_cycle", {31'd0, round_ack}, 32'd0);
    step(2);
    check_eq("show_held_t3", {30'd0, state}, 32'd2);
    step(1);
    check_eq("show_end_play", {30'd0, state}, 32'd1);

    // FPGA win, then a result dropped during SHOW
    accept_round(2'b01);
    step(2);
    pulse(1'b1, 2'b01, 1'b0);
    check_eq("show_drop_fpga", {29'd0, fpga_score}, 32'd1);
    check_eq("show_drop_ack", {31'd0, round_ack}, 32'd0);
    check_eq("show_drop_state", {30'd0, state}, 32'd2);
    step(1);
    check_eq("show_drop_play", {30'd0, state}, 32'd1);

    // code 00 in PLAY
    pulse(1'b1, 2'b00, 1'b0);
    check_eq("none_code_ack", {31'd0, round_ack}, 32'd0);
    check_eq("none_code_state", {30'd0, state}, 32'd1);

    // second user win, then new_match collides with a result
    accept_round(2'b10);
    step(4);
    check_eq("pre_collide_user", {29'd0, user_score}, 32'd2);
    pulse(1'b1, 2'b10, 1'b1);
    model_new_match();
    check_eq("collide_user", {29'd0, user_score}, 32'd0);
    check_eq("collide_fpga", {29'd0, fpga_score}, 32'd0);
    check_eq("collide_round", {24'd0, round_count}, 32'd0);
    check_eq("collide_ack", {31'd0, round_ack}, 32'd0);
    check_eq("collide_state", {30'd0, state}, 32'd1);

    // three user wins end the match
    for (int i = 0; i < 3; i++) begin
      accept_round(2'b10);
      step(4);
    end
    check_eq("over_state", {30'd0, state}, 32'd3);
    check_eq("over_done", {31'd0, match_done}, 32'd1);
    check_eq("over_winner", {30'd0, match_winner}, 32'd2);
    pulse(1'b1, 2'b10, 1'b0);
    step(1);
    check_eq("over_frozen_user", {29'd0, user_score}, 32'd3);
    check_eq("over_frozen_state", {30'd0, state}, 32'd3);

    // new match from OVER; history sequence 10, 01, 11
    pulse(1'b0, 2'b00, 1'b1);
    model_new_match();
    check_eq("over_restart_state", {30'd0, state}, 32'd1);
    check_eq("over_restart_done", {31'd0, match_done}, 32'd0);
    check_eq("over_restart_win", {30'd0, match_winner}, 32'd0);
    accept_round(2'b10);
    step(4);
    accept_round(2'b01);
    step(4);
    accept_round(2'b11);
    step(4);
`ifdef RPS_HISTORY_EN
    check_eq("history_seq", {16'd0, history}, 32'h0027);
`else
    check_eq("history_tied", {16'd0, history}, 32'h0000);
`endif

    // eight draws saturate the draw tally
    pulse(1'b0, 2'b00, 1'b1);
    model_new_match();
    for (int i = 0; i < 8; i++) begin
      accept_round(2'b11);
      step(4);
    end
    check_eq("draw_sat", {29'd0, draw_count}, 32'd7);
    check_eq("draw_rounds", {24'd0, round_count}, 32'd8);
    check_eq("draw_user", {29'd0, user_score}, 32'd0);
    check_eq("draw_fpga", {29'd0, fpga_score}, 32'd0);
    check_eq("draw_state", {30'd0, state}, 32'd1);

    // clear mid-SHOW takes effect without a clock edge
    accept_round(2'b10);
    step(1);
    #1;
    clear = 1'b1;
    #2;
    check_all_zero("async_clear");
    step(1);
    clear = 1'b0;
    step(2);
    check_eq("post_clear_state", {30'd0, state}, 32'd0);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_scorer.md
Name: rps_match_scorer

Overview:
- Downstream of the rock-paper-scissors round judge: consumes each 2-bit round result and keeps user, FPGA and draw tallies.
- Runs a first-to-WIN_TARGET match state machine.
- Holds each round outcome on display for a fixed time before accepting the next round.
- Its outputs feed the LED-matrix scan logic and the score indicators.

Parameters:
- WIN_TARGET, 3: round wins needed to take the match; range 1..2^SCORE_W-1.
- SCORE_W, 3: width of the user, FPGA and draw tallies.
- DISP_HOLD, 25000000: clk cycles spent in SHOW after each accepted round; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- result_in  in  2  round code: 2'b11 draw, 2'b01 FPGA wins, 2'b10 user wins, 2'b00 none.
- result_valid  in  1  one-cycle strobe qualifying result_in.
- new_match  in  1  one-cycle strobe: zero tallies and start a match.
- user_score  out  SCORE_W  user round wins.
- fpga_score  out  SCORE_W  FPGA round wins.
- draw_count  out  SCORE_W  draws, saturating.
- round_count  out  8  accepted rounds, wrapping.
- round_ack  out  1  one-cycle pulse per accepted round.
- last_result  out  2  code of the most recently accepted round.
- state  out  2  FSM state code.
- match_done  out  1  high while in OVER.
- match_winner  out  2  2'b00 none, 2'b01 FPGA, 2'b10 user.
- history  out  16  last 8 accepted codes, newest in [1:0].

Behaviour:
- Reset: clear is asynchronous, active-high.
  - All outputs go to 0; state goes to IDLE; the hold counter goes to 0.
  - Reset asserted mid-SHOW or mid-OVER aborts immediately.
- State codes: IDLE=2'b00, PLAY=2'b01, SHOW=2'b10, OVER=2'b11. state drives the registered FSM state directly.
- IDLE:
  - result_valid is ignored.
  - new_match moves to PLAY and zeroes every tally, round_count, last_result and match_winner.
- PLAY:
  - A round is accepted when result_valid=1 and result_in≠2'b00.
  - On the next edge the matching tally increments, round_count increments (255→0), last_result is loaded, round_ack pulses high for exactly one cycle, and the FSM enters SHOW with the hold counter at 0.
  - result_valid with code 2'b00 produces no ack and no state change.
- SHOW:
  - Lasts exactly DISP_HOLD cycles, after which the FSM evaluates the scores.
  - If user_score==WIN_TARGET: go to OVER with match_winner=2'b10.
  - Else if fpga_score==WIN_TARGET: go to OVER with match_winner=2'b01.
  - Otherwise return to PLAY.
  - result_valid during SHOW is dropped: no ack, no count.
- OVER:
  - match_done=1; tallies are frozen and result_valid is ignored.
  - new_match zeroes everything as in IDLE and enters PLAY.
- new_match in PLAY or SHOW restarts the match: zero everything, go to PLAY.
- new_match and result_valid in the same cycle: new_match wins and the result is discarded.
- Saturation and wrap:
  - draw_count saturates at 2^SCORE_W-1.
  - user_score and fpga_score cannot exceed WIN_TARGET because the match ends first.
- Latency: scores, round_ack and last_result become visible 1 cycle after the accepting edge.
  - With no intervening events, the earliest next acceptance is DISP_HOLD+1 cycles after round_ack.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: RPS_HISTORY_EN.
- Defined:
  - history is an 8-deep shift register of accepted codes.
  - On acceptance: history <= {history[13:0], result_in}.
  - Zeroed by clear and by new_match.
  - Draws are recorded as 2'b11.
- Undefined: history is tied to 16'h0000 and the shift logic is not built.
- The port list is identical in both builds.

Test Plan (WIN_TARGET=3, SCORE_W=3, DISP_HOLD=4):
- Reset, then new_match, then result_valid with 2'b10 → next cycle: user_score=1, round_ack=1 for one cycle, state=SHOW; state=PLAY 4 cycles later.
- Three user wins separated by ≥5 cycles → after the 3rd SHOW: state=OVER, match_done=1, match_winner=2'b10; a further result_valid leaves user_score=3.
- result_valid with 2'b01 issued 2 cycles into SHOW → ignored: fpga_score unchanged, no round_ack; result_valid with 2'b00 in PLAY → no ack, state stays PLAY.
- 8 draws → draw_count=7 and saturated, round_count=8, user_score=0, fpga_score=0, state=PLAY.
- new_match and result_valid (2'b10) in the same cycle while in PLAY with user_score=2 → all tallies 0, no ack, state=PLAY; clear asserted mid-SHOW → all outputs 0 asynchronously, state=IDLE.
- With RPS_HISTORY_EN: accepted sequence 10, 01, 11 → history=16'h0027. Without the macro: history stays 16'h0000.
